// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_ctrl
// Function : Round-robin scan scheduler for an 8-digit seven-segment display.
//            Holds a hex value plus decimal point per digit. Visits each enabled
//            digit for DWELL_CYC cycles, preceded by a BLANK_CYC all-off gap to
//            suppress ghosting. Drives the shared segment bus and the one-hot
//            digit enables.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl #(
  parameter int DWELL_CYC = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic [7:0] digit_en,
  output logic [7:0] Enable,
  output logic [7:0] SevenSeg,
  output logic [2:0] scan_idx,
  output logic       frame_done
);

  // The counter only ever needs to reach the longer of the two phase lengths minus one.
  localparam int c_MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYC - 1);

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [4:0]           r_mem [8];   // {dp, value[3:0]}
  logic [7:0]           r_enable;
  logic [7:0]           r_seg;
  logic [2:0]           r_idx;
  logic                 r_frame;

  logic [2:0]           w_next_idx;
  logic                 w_any_en;

  // Hex value to active-high segments g..a.
  function automatic logic [6:0] f_hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h27;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Full bus pattern for a stored entry: dp on bit 7, segments below.
  function automatic logic [7:0] f_encode(input logic [4:0] entry);
    return {entry[4], f_hex7(entry[3:0])};
  endfunction

  // Circular search for the first enabled digit after the current index.
  // Iterating from the farthest offset down lets the nearest hit win; offset 8
  // wraps back onto the current digit, which covers the single-digit case.
  always_comb begin
    w_next_idx = r_idx;
    w_any_en   = |digit_en;
    for (int k = 8; k >= 1; k--) begin
      if (digit_en[r_idx + 3'(k)]) begin
        w_next_idx = r_idx + 3'(k);
      end
    end
  end

  // Register file, blank/show sequencing and registered pin drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_BLANK;
      r_cnt    <= '0;
      r_enable <= '0;
      r_seg    <= '0;
      r_idx    <= 3'd7;
      r_frame  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        r_mem[wr_addr] <= {wr_dp, wr_data};
      end
      r_frame <= 1'b0;
      case (r_state)
        S_BLANK: begin
          r_enable <= '0;
          r_seg    <= '0;
          if (r_cnt == c_BLANK_LAST) begin
            r_cnt <= '0;
            // With nothing enabled the gap simply restarts and the index holds.
            if (w_any_en) begin
              r_state  <= S_SHOW;
              r_idx    <= w_next_idx;
              r_enable <= 8'b1 << w_next_idx;
              r_seg    <= f_encode(r_mem[w_next_idx]);
              r_frame  <= (w_next_idx <= r_idx);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SHOW: begin
          // Re-read the entry every cycle so writes to the lit digit show up
          // one cycle after the write edge.
          r_enable <= 8'b1 << r_idx;
          r_seg    <= f_encode(r_mem[r_idx]);
          if (r_cnt == c_DWELL_LAST) begin
            r_cnt    <= '0;
            r_state  <= S_BLANK;
            r_enable <= '0;
            r_seg    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= S_BLANK;
          r_cnt    <= '0;
          r_enable <= '0;
          r_seg    <= '0;
        end
      endcase
    end
  end

  assign Enable     = r_enable;
  assign SevenSeg   = r_seg;
  assign scan_idx   = r_idx;
  assign frame_done = r_frame;

endmodule
`default_nettype wire

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexing scheduler for the board's 8-digit seven-segment display. Holds one 4-bit hex value plus decimal point per digit, scans enabled digits round-robin with a fixed dwell time and an anti-ghosting blank gap, and drives the shared `SevenSeg` bus and one-hot `Enable` lines. Sits between switch/LED lab logic (writers) and the display pins, replacing static single-digit drive.

## Interface
- `DWELL_CYC`, 50000: clock cycles each digit is lit per visit (≥1).
- `BLANK_CYC`, 500: clock cycles with all digits off before each digit is lit (≥1).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe for digit register file.
- `wr_addr`  in  3  digit index to write (0 = `Enable[0]`).
- `wr_data`  in  4  hex value 0x0–0xF for that digit.
- `wr_dp`  in  1  decimal point for that digit.
- `digit_en`  in  8  per-digit scan enable; disabled digits are skipped.
- `Enable`  out  8  one-hot digit enable, active-high; all-zero while blanking.
- `SevenSeg`  out  8  segments, active-high: bit7 = dp, bits6:0 = g f e d c b a.
- `scan_idx`  out  3  index of digit currently lit / last lit.
- `frame_done`  out  1  one-cycle pulse when the scan wraps.

## Operation
- Digit register file: 8 entries × {value[3:0], dp}. On `wr_en`, entry `wr_addr` updates at that clock edge. No read-back; writes always accepted, no handshake.
- Encoder (value → bits6:0): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→27, 8→7F, 9→6F, A→77, B→7C, C→39, D→5E, E→79, F→71. bit7 = stored dp.
- FSM states BLANK, SHOW; one cycle counter `cnt`.
- BLANK: `Enable`=0, `SevenSeg`=0. Counts BLANK_CYC cycles. On last cycle: if `digit_en`≠0, select next index = first set bit of `digit_en` searching circularly from `scan_idx`+1 (mod 8); load `scan_idx`; go SHOW, `cnt`=0. If `digit_en`=0, stay BLANK, restart count, `scan_idx` unchanged.
- SHOW: `Enable`=one-hot(`scan_idx`), `SevenSeg`=encode(entry[`scan_idx`]). Counts DWELL_CYC cycles, then BLANK.
- `digit_en` sampled only at the BLANK→SHOW decision; clearing the current digit's bit mid-SHOW does not cut its dwell.
- Write to the currently lit digit: new segments appear on `SevenSeg` one cycle after the write edge, within the same dwell.
- `frame_done`: pulses the cycle SHOW is entered when the new index ≤ previous `scan_idx` (wrap), including single-digit case (every visit).

## Timing
- All outputs registered; reset values: `Enable`=0, `SevenSeg`=0, `scan_idx`=7, `frame_done`=0, state BLANK, `cnt`=0, all entries {0,0}.
- Reset asserted mid-SHOW: outputs cleared at next edge; entries cleared.
- Cycle 0 = first edge with `reset` low. All digits enabled: cycles 0..BLANK_CYC−1 blank, digit 0 lit for cycles BLANK_CYC..BLANK_CYC+DWELL_CYC−1, then blank, then digit 1, etc.
- Per-visit period = BLANK_CYC + DWELL_CYC; full frame = N_enabled × period.
- `Enable` and `SevenSeg` change on the same edge; never more than one `Enable` bit set.
- Write latency to pins: write edge t → visible at edge t+1 if that digit is lit.

## Test plan
- DWELL=4, BLANK=1, all enabled, entry i = i, no dp -> after reset: 1 blank cycle, `Enable`=01 `SevenSeg`=3F ×4, blank, `Enable`=02 `SevenSeg`=06 ×4 … digit 7 `SevenSeg`=27, wrap to digit 0 with `frame_done` pulse.
- `digit_en`=8'b1000_0100, entries 2=0xA dp=1, 7=0xF -> only `Enable`=04 (`SevenSeg`=F7) and 80 (`SevenSeg`=71) alternate; `frame_done` on each return to digit 2.
- `digit_en`=0 -> `Enable`=0, `SevenSeg`=0 indefinitely, no `frame_done`; set to 8'h01 -> digit 0 lit after ≤ BLANK_CYC cycles, `frame_done` every visit.
- While digit 3 lit, write addr 3 data 0x8 dp=1 -> `SevenSeg`=FF one cycle later, same dwell; write addr 5 -> no change on pins until digit 5 lit.
- Clear `digit_en[3]` during digit 3 dwell -> full dwell completes, next visit skips 3.
- Assert `reset` for 1 cycle mid-SHOW -> all outputs 0 next edge, scan restarts at digit 0 showing 3F (entries cleared).
